wb_write_arbiter: RTL

- Initiator side of the register-file write port: the only block that drives the register file's single write port (WriteEnable/DAddress/DData).
- Merges two producers: in-order pipeline writeback results, and out-of-order results from the long-latency multiply/divide unit.
- Keeps a per-register pending-write scoreboard so decode can stall on registers whose multiply/divide result has not yet been written.

---
 rtl/wb_write_arbiter_pkg.sv | 16 +
 rtl/wb_write_arbiter_md_result_fifo.sv | 59 +++++
 rtl/wb_write_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_write_arbiter_pkg;

  localparam int unsigned DATA_BITS_DEF = 32;
  localparam int unsigned ADDR_BITS_DEF = 5;

  localparam logic [ADDR_BITS_DEF-1:0] REG_ZERO = '0;

  // Write request from either producer (pipeline writeback or mul/div result)
  typedef struct packed {
    logic                     valid;
    logic [ADDR_BITS_DEF-1:0] addr;
    logic [DATA_BITS_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_write_arbiter_md_result_fifo.sv
// Small synchronous FIFO holding mul/div results until they win the write port.
module md_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [PTR_BITS-1:0] r_wr_ptr;
  logic [PTR_BITS-1:0] r_rd_ptr;
  logic [CNT_BITS-1:0] r_count;
  logic                w_do_push;
  logic                w_do_pop;

  assign o_full    = (r_count == CNT_BITS'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_BITS'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Sole driver of the register-file write port: merges pipeline writeback with
// out-of-order mul/div results and tracks registers awaiting a mul/div write.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned ADDR_BITS    = ADDR_BITS_DEF,
  parameter int unsigned DEPTH        = 1 << ADDR_BITS,
  parameter int unsigned MD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [ADDR_BITS-1:0] wb_addr,
  input  logic [DATA_BITS-1:0] wb_data,
  output logic                 wb_stall,
  input  logic                 md_issue,
  input  logic [ADDR_BITS-1:0] md_issue_addr,
  input  logic                 md_valid,
  output logic                 md_ready,
  input  logic [ADDR_BITS-1:0] md_addr,
  input  logic [DATA_BITS-1:0] md_data,
  input  logic [ADDR_BITS-1:0] q_a_addr,
  input  logic [ADDR_BITS-1:0] q_b_addr,
  output logic                 q_a_busy,
  output logic                 q_b_busy,
  output logic                 WriteEnable,
  output logic [ADDR_BITS-1:0] DAddress,
  output logic [DATA_BITS-1:0] DData
);

  localparam int unsigned ENTRY_BITS = ADDR_BITS + DATA_BITS;
  localparam int unsigned CNT_BITS   = $clog2(STARVE_LIMIT + 1);

  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ENTRY_BITS-1:0] w_fifo_head;
  logic [ADDR_BITS-1:0]  w_head_addr;
  logic [DATA_BITS-1:0]  w_head_data;

  logic [CNT_BITS-1:0]   r_starve;
  logic                  w_stall;
  logic                  w_eff_wb;
  wr_req_t               w_win;
  logic                  w_do_write;

  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_daddr;
  logic [DATA_BITS-1:0]  r_ddata;

  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_d;

  // ---------------------------------------------------------------------------
  // Mul/div result buffer
  // ---------------------------------------------------------------------------
  assign md_ready    = !w_fifo_full;
  assign w_fifo_push = md_valid && md_ready;

  md_result_fifo #(
    .WIDTH (ENTRY_BITS),
    .DEPTH (MD_DEPTH)
  ) u_md_result_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_fifo_push),
    .i_push_data ({md_addr, md_data}),
    .i_pop       (w_fifo_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  assign w_head_addr = w_fifo_head[ENTRY_BITS-1:DATA_BITS];
  assign w_head_data = w_fifo_head[DATA_BITS-1:0];

  // ---------------------------------------------------------------------------
  // Arbitration: pipeline has priority until the mul/div head has waited long
  // enough, then the pipeline is held for exactly one cycle.
  // ---------------------------------------------------------------------------
  assign w_stall    = (r_starve == CNT_BITS'(STARVE_LIMIT)) && !w_fifo_empty;
  assign wb_stall   = w_stall;
  assign w_eff_wb   = wb_valid && !w_stall;
  assign w_fifo_pop = !w_eff_wb && !w_fifo_empty;

  always_comb begin
    w_win = '0;
    if (w_eff_wb) begin
      w_win.valid = 1'b1;
      w_win.addr  = wb_addr;
      w_win.data  = wb_data;
    end else if (w_fifo_pop) begin
      w_win.valid = 1'b1;
      w_win.addr  = w_head_addr;
      w_win.data  = w_head_data;
    end
  end

  // Register 0 winners are consumed but never reach the register file
  assign w_do_write = w_win.valid && (w_win.addr != REG_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_eff_wb && !w_fifo_empty) begin
      if (r_starve != CNT_BITS'(STARVE_LIMIT)) begin
        r_starve <= r_starve + CNT_BITS'(1);
      end
    end else if (w_fifo_pop) begin
      r_starve <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write port; address/data hold when no write is issued
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_daddr <= '0;
      r_ddata <= '0;
    end else begin
      r_we <= w_do_write;
      if (w_do_write) begin
        r_daddr <= w_win.addr;
        r_ddata <= w_win.data;
      end
    end
  end

  assign WriteEnable = r_we;
  assign DAddress    = r_daddr;
  assign DData       = r_ddata;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard; a new issue overrides a same-cycle retirement
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy_d = r_busy;
    if (w_fifo_pop) begin
      w_busy_d[w_head_addr] = 1'b0;
    end
    if (md_issue && (md_issue_addr != REG_ZERO)) begin
      w_busy_d[md_issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign q_a_busy = r_busy[q_a_addr] && (q_a_addr != REG_ZERO);
  assign q_b_busy = r_busy[q_b_addr] && (q_b_addr != REG_ZERO);

endmodule
